// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the main-memory port arbiter (mem_arbiter)
// and its grant picker (mem_arb_grant).
//   DEF_ADDR_W / DEF_LINE_W : default byte-address and line widths
//   REQ_I / REQ_D           : requester IDs (instruction = 0, data = 1)
//   arb_state_e             : transaction sequencer states
//   id_onehot()             : requester ID -> one-hot grant vector
// Build option: MEM_ARB_RR_EN (round-robin contention policy) is consumed by
// mem_arb_grant and mem_arbiter; nothing in this package depends on it.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   localparam int unsigned DEF_ADDR_W = 32;
   localparam int unsigned DEF_LINE_W = 128;

   localparam logic REQ_I = 1'b0;
   localparam logic REQ_D = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

   // Bit 0 of a grant vector belongs to the instruction side, bit 1 to data.
   function automatic logic [1:0] id_onehot(input logic id);
      return (id == REQ_D) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// -----------------------------------------------------------------------------
// mem_arb_grant
// Combinational two-way picker for the memory arbiter.
// Ports:
//   valid[1:0]  in   request valids, [0] = instruction, [1] = data
//   last_grant  in   requester granted most recently (round-robin only)
//   en          in   arbiter may accept a request this cycle
//   gnt[1:0]    out  one-hot grant, all zero when disabled or nothing valid
//   gnt_id      out  ID of the requester that would win
// Build option MEM_ARB_RR_EN: when defined, contention goes to the requester
// other than last_grant; otherwise the data side always wins contention.
// A lone valid requester always wins.
// -----------------------------------------------------------------------------
module mem_arb_grant
   import mem_arb_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       last_grant,
   input  logic       en,
   output logic [1:0] gnt,
   output logic       gnt_id
);

`ifndef MEM_ARB_RR_EN
   // Fixed priority has no use for history; keep the port without a dangling net.
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

   always_comb begin
      // NOTE: every output gets a default first so no path through the block
      // leaves it unassigned, which would infer a latch.
      gnt_id = REQ_D;
      gnt    = 2'b00;
      case (valid)
         2'b01:   gnt_id = REQ_I;
         2'b10:   gnt_id = REQ_D;
         2'b11: begin
`ifdef MEM_ARB_RR_EN
            gnt_id = ~last_grant;
`else
            gnt_id = REQ_D;
`endif
         end
         default: gnt_id = REQ_D;
      endcase
      if (en && (valid != 2'b00)) begin
         gnt = id_onehot(gnt_id);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one line-wide main-memory port between the instruction refill path
// (requester 0) and the data refill/writeback path (requester 1). One
// transaction at a time: IDLE (grant) -> ISSUE (mem valid/ready) -> WAIT
// (memory completion) -> RESP (one-cycle pulse to the owner) -> IDLE.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   {i,d}_req_valid/ready         request handshake per requester
//   {i,d}_req_write/addr/wdata    request fields (addr low 4 bits dropped)
//   {i,d}_resp_valid              one-cycle completion pulse per requester
//   resp_rdata                    read line, shared, qualified by *_resp_valid
//   mem_req_valid/ready           request handshake towards memory
//   mem_write/addr/wdata          latched request fields towards memory
//   mem_resp_valid, mem_rdata     memory completion and read line
//   busy                          a transaction is in flight (state != IDLE)
//   grant_id                      owner of the current/last transaction
// Build option MEM_ARB_RR_EN: round-robin on contention using last_grant;
// undefined gives fixed data-over-instruction priority and no last_grant.
// -----------------------------------------------------------------------------
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned LINE_W = DEF_LINE_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req_valid,
   output logic              i_req_ready,
   input  logic              i_req_write,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [LINE_W-1:0] i_req_wdata,
   input  logic              d_req_valid,
   output logic              d_req_ready,
   input  logic              d_req_write,
   input  logic [ADDR_W-1:0] d_req_addr,
   input  logic [LINE_W-1:0] d_req_wdata,
   output logic              i_resp_valid,
   output logic              d_resp_valid,
   output logic [LINE_W-1:0] resp_rdata,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic              mem_resp_valid,
   input  logic [LINE_W-1:0] mem_rdata,
   output logic              busy,
   output logic              grant_id
);

   // Clears the byte-in-line offset of a 16-byte line address.
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(4'hF);

   arb_state_e        state_q;
   logic              grant_id_q;
   logic              write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic [LINE_W-1:0] rdata_q;
   logic              mem_req_valid_q;
   logic              busy_q;
   logic              i_resp_q;
   logic              d_resp_q;

   logic [1:0]        gnt;
   logic              gnt_id;
   logic              last_grant;
   logic              accept;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [LINE_W-1:0] sel_wdata;

`ifdef MEM_ARB_RR_EN
   logic last_grant_q;
   assign last_grant = last_grant_q;
`else
   assign last_grant = REQ_I;
`endif

   // Grants are only offered in IDLE and never while reset is asserted, so a
   // requester cannot see a handshake that reset then discards.
   mem_arb_grant u_grant (
      .valid      ({d_req_valid, i_req_valid}),
      .last_grant (last_grant),
      .en         ((state_q == ST_IDLE) && !reset),
      .gnt        (gnt),
      .gnt_id     (gnt_id)
   );

   assign i_req_ready = gnt[0];
   assign d_req_ready = gnt[1];
   assign accept      = |gnt;

   assign sel_write = (gnt_id == REQ_D) ? d_req_write : i_req_write;
   assign sel_addr  = (gnt_id == REQ_D) ? d_req_addr  : i_req_addr;
   assign sel_wdata = (gnt_id == REQ_D) ? d_req_wdata : i_req_wdata;

   // NOTE: all state, including registered outputs, uses non-blocking
   // assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the address/data holding registers are reset as well because
         // they drive outputs that must read zero out of reset.
         state_q         <= ST_IDLE;
         grant_id_q      <= REQ_I;
         write_q         <= 1'b0;
         addr_q          <= '0;
         wdata_q         <= '0;
         rdata_q         <= '0;
         mem_req_valid_q <= 1'b0;
         busy_q          <= 1'b0;
         i_resp_q        <= 1'b0;
         d_resp_q        <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_grant_q    <= REQ_I;
`endif
      end else begin
         // Response strobes are single-cycle unless re-armed below.
         i_resp_q <= 1'b0;
         d_resp_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  grant_id_q      <= gnt_id;
                  write_q         <= sel_write;
                  addr_q          <= sel_addr & LINE_MASK;
                  wdata_q         <= sel_wdata;
                  mem_req_valid_q <= 1'b1;
                  busy_q          <= 1'b1;
                  state_q         <= ST_ISSUE;
`ifdef MEM_ARB_RR_EN
                  last_grant_q    <= gnt_id;
`endif
               end
            end
            ST_ISSUE: begin
               if (mem_req_ready) begin
                  mem_req_valid_q <= 1'b0;
                  state_q         <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_resp_valid) begin
                  rdata_q  <= mem_rdata;
                  i_resp_q <= (grant_id_q == REQ_I);
                  d_resp_q <= (grant_id_q == REQ_D);
                  state_q  <= ST_RESP;
               end
            end
            ST_RESP: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               mem_req_valid_q <= 1'b0;
               busy_q          <= 1'b0;
               state_q         <= ST_IDLE;
            end
         endcase
      end
   end

   assign i_resp_valid  = i_resp_q;
   assign d_resp_valid  = d_resp_q;
   assign resp_rdata    = rdata_q;
   assign mem_req_valid = mem_req_valid_q;
   assign mem_write     = write_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign busy          = busy_q;
   assign grant_id      = grant_id_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. A transaction-level reference model
// (one outstanding request, a line memory held in an associative array)
// predicts handshakes, memory-side fields and responses every cycle.
// Directed sequences cover the single read, contention order, memory stalls,
// write-then-read and reset mid-transaction; a randomized phase follows.
// Build option MEM_ARB_RR_EN selects the round-robin expectation.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
   import mem_arb_pkg::*;

`ifdef MEM_ARB_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         i_req_valid, i_req_ready, i_req_write;
   logic [31:0]  i_req_addr;
   logic [127:0] i_req_wdata;
   logic         d_req_valid, d_req_ready, d_req_write;
   logic [31:0]  d_req_addr;
   logic [127:0] d_req_wdata;
   logic         i_resp_valid, d_resp_valid;
   logic [127:0] resp_rdata;
   logic         mem_req_valid, mem_req_ready, mem_write;
   logic [31:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic         mem_resp_valid;
   logic [127:0] mem_rdata;
   logic         busy, grant_id;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk            (clk),
      .reset          (reset),
      .i_req_valid    (i_req_valid),
      .i_req_ready    (i_req_ready),
      .i_req_write    (i_req_write),
      .i_req_addr     (i_req_addr),
      .i_req_wdata    (i_req_wdata),
      .d_req_valid    (d_req_valid),
      .d_req_ready    (d_req_ready),
      .d_req_write    (d_req_write),
      .d_req_addr     (d_req_addr),
      .d_req_wdata    (d_req_wdata),
      .i_resp_valid   (i_resp_valid),
      .d_resp_valid   (d_resp_valid),
      .resp_rdata     (resp_rdata),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_write      (mem_write),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_resp_valid (mem_resp_valid),
      .mem_rdata      (mem_rdata),
      .busy           (busy),
      .grant_id       (grant_id)
   );

   typedef struct packed {
      logic         id;
      logic         wr;
      logic [31:0]  addr;
      logic [127:0] wdata;
   } txn_t;

   int checks    = 0;
   int errors    = 0;
   int cyc       = 0;
   int acc_cyc   = 0;
   int pulse_cyc = 0;
   int i_pulses  = 0;
   int d_pulses  = 0;

   // Reference model: is a transaction open, has memory taken it, is the
   // response pulse due this cycle, and who won the last grant.
   bit   m_open     = 1'b0;
   bit   m_issued   = 1'b0;
   bit   m_resp_now = 1'b0;
   bit   m_last     = 1'b0;
   txn_t cur;
   logic [127:0] mem_m [logic [31:0]];
   logic grants[$];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] mem_read(input logic [31:0] a);
      if (mem_m.exists(a)) return mem_m[a];
      return {4{a ^ 32'h5EED_0000}};
   endfunction

   function automatic bit chance(input int unsigned pct);
      return $urandom_range(0, 99) < pct;
   endfunction

   // One clock cycle: entered at a falling edge with inputs already driven.
   task automatic tick();
      logic [1:0] v;
      logic [1:0] exp_rdy;
      logic       exp_id;
      bit         exp_mv;
      // Memory returns the stored line while the model waits on a read.
      if (m_issued && !m_resp_now && !cur.wr) mem_rdata = mem_read(cur.addr);
      else mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      v       = {d_req_valid, i_req_valid};
      exp_rdy = 2'b00;
      exp_id  = 1'b0;
      if (!m_open && !reset && (v != 2'b00)) begin
         if (v == 2'b01)      exp_id = 1'b0;
         else if (v == 2'b10) exp_id = 1'b1;
         else                 exp_id = RR_EN ? ~m_last : 1'b1;
         exp_rdy = exp_id ? 2'b10 : 2'b01;
      end
      check("ready", 128'({d_req_ready, i_req_ready}), 128'(exp_rdy));
      check("busy", 128'(busy), 128'(m_open));
      exp_mv = m_open && !m_issued;
      check("mem_req_valid", 128'(mem_req_valid), 128'(exp_mv));
      if (exp_mv) begin
         check("mem_write", 128'(mem_write), 128'(cur.wr));
         check("mem_addr", 128'(mem_addr), 128'(cur.addr));
         if (cur.wr) check("mem_wdata", mem_wdata, cur.wdata);
      end
      if (m_open) check("grant_id", 128'(grant_id), 128'(cur.id));
      check("i_resp_valid", 128'(i_resp_valid), 128'(m_resp_now && !cur.id));
      check("d_resp_valid", 128'(d_resp_valid), 128'(m_resp_now && cur.id));
      if (m_resp_now && !cur.wr) check("resp_rdata", resp_rdata, mem_read(cur.addr));
      if (i_resp_valid) i_pulses++;
      if (d_resp_valid) d_pulses++;
      if (m_resp_now) pulse_cyc = cyc;

      // Advance the model across the coming rising edge.
      if (reset) begin
         m_open = 1'b0; m_issued = 1'b0; m_resp_now = 1'b0; m_last = 1'b0;
      end else if (!m_open) begin
         if (exp_rdy != 2'b00) begin
            m_open     = 1'b1;
            cur.id     = exp_id;
            cur.wr     = exp_id ? d_req_write : i_req_write;
            cur.addr   = (exp_id ? d_req_addr : i_req_addr) & 32'hFFFF_FFF0;
            cur.wdata  = exp_id ? d_req_wdata : i_req_wdata;
            m_last     = exp_id;
            acc_cyc    = cyc;
            grants.push_back(exp_id);
         end
      end else if (!m_issued) begin
         if (mem_req_ready) begin
            m_issued = 1'b1;
            if (cur.wr) mem_m[cur.addr] = cur.wdata;
         end
      end else if (!m_resp_now) begin
         if (mem_resp_valid) m_resp_now = 1'b1;
      end else begin
         m_open = 1'b0; m_issued = 1'b0; m_resp_now = 1'b0;
      end
      cyc++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      reset = 1'b0;
      i_req_valid = 1'b0; i_req_write = 1'b0; i_req_addr = '0; i_req_wdata = '0;
      d_req_valid = 1'b0; d_req_write = 1'b0; d_req_addr = '0; d_req_wdata = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic rand_inputs();
      reset          = ($urandom_range(0, 199) == 0);
      i_req_valid    = chance(55);
      d_req_valid    = chance(55);
      i_req_write    = chance(30);
      d_req_write    = chance(30);
      i_req_addr     = {24'h0, 4'($urandom_range(0, 15)), 4'($urandom)};
      d_req_addr     = {24'h0, 4'($urandom_range(0, 15)), 4'($urandom)};
      i_req_wdata    = {$urandom, $urandom, $urandom, $urandom};
      d_req_wdata    = {$urandom, $urandom, $urandom, $urandom};
      mem_req_ready  = chance(60);
      mem_resp_valid = chance(50);
   endtask

   initial begin
      int base;
      logic [127:0] w;
      idle_inputs();
      reset     = 1'b1;
      mem_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      // Reset state of every output.
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_mem_req_valid", 128'(mem_req_valid), 128'(0));
      check("rst_mem_write", 128'(mem_write), 128'(0));
      check("rst_mem_addr", 128'(mem_addr), 128'(0));
      check("rst_mem_wdata", mem_wdata, 128'(0));
      check("rst_grant_id", 128'(grant_id), 128'(0));
      check("rst_resp_rdata", resp_rdata, 128'(0));
      check("rst_resp_valid", 128'({d_resp_valid, i_resp_valid}), 128'(0));
      check("rst_ready", 128'({d_req_ready, i_req_ready}), 128'(0));
      @(negedge clk);

      // Single data-side read with the fastest memory.
      do_reset();
      mem_m[32'h0000_1230] = {16{8'hA5}};
      d_req_valid = 1'b1; d_req_addr = 32'h0000_1234; d_req_write = 1'b0;
      mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
      base = i_pulses;
      tick();
      d_req_valid = 1'b0;
      repeat (5) tick();
      check("rd_latency", 128'(pulse_cyc - acc_cyc), 128'(3));
      check("rd_data", resp_rdata, {16{8'hA5}});
      check("rd_no_i_pulse", 128'(i_pulses - base), 128'(0));

      // Continuous contention: four back-to-back grants.
      do_reset();
      grants.delete();
      mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
      for (int k = 0; k < 16; k++) begin
         i_req_valid = 1'b1; d_req_valid = 1'b1;
         i_req_write = chance(50); d_req_write = chance(50);
         i_req_addr = $urandom; d_req_addr = $urandom;
         i_req_wdata = {4{$urandom}}; d_req_wdata = {4{$urandom}};
         tick();
      end
      check("cont_count", 128'(grants.size()), 128'(4));
      for (int k = 0; k < grants.size(); k++) begin
         check("cont_order", 128'(grants[k]), 128'(RR_EN ? ((k % 2) == 0) : 1'b1));
      end
      d_req_valid = 1'b0;
      repeat (6) tick();
      i_req_valid = 1'b0;
      repeat (4) tick();

      // Memory stalls: ready held low three cycles, response five cycles late.
      do_reset();
      base = i_pulses;
      i_req_valid = 1'b1; i_req_addr = 32'h0000_0ABC; i_req_write = 1'b1;
      i_req_wdata = {4{32'h1234_5678}};
      tick();
      i_req_valid = 1'b0;
      repeat (3) tick();
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      repeat (4) tick();
      mem_resp_valid = 1'b1;
      tick();
      mem_resp_valid = 1'b0;
      repeat (3) tick();
      check("stall_pulses", 128'(i_pulses - base), 128'(1));

      // Instruction-side write then read of the same line.
      do_reset();
      base = i_pulses;
      w = {32'hC0FF_EE11, 32'h2233_4455, 32'h6677_8899, 32'hAABB_CCDD};
      mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
      i_req_valid = 1'b1; i_req_write = 1'b1; i_req_addr = 32'h0000_0040; i_req_wdata = w;
      tick();
      i_req_valid = 1'b0;
      repeat (3) tick();
      i_req_valid = 1'b1; i_req_write = 1'b0; i_req_wdata = '0;
      tick();
      i_req_valid = 1'b0;
      repeat (4) tick();
      check("wr_rd_pulses", 128'(i_pulses - base), 128'(2));
      check("wr_rd_data", resp_rdata, w);

      // Reset while waiting on memory, then a stale completion.
      do_reset();
      base = d_pulses;
      d_req_valid = 1'b1; d_req_addr = 32'h0000_2000; d_req_write = 1'b0;
      mem_req_ready = 1'b1;
      tick();
      d_req_valid = 1'b0;
      tick();
      mem_req_ready = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mem_resp_valid = 1'b1;
      repeat (2) tick();
      mem_resp_valid = 1'b0;
      check("rst_wait_pulses", 128'(d_pulses - base), 128'(0));
      check("rst_wait_idle", 128'(busy), 128'(0));
      d_req_valid = 1'b1; mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
      tick();
      d_req_valid = 1'b0;
      repeat (4) tick();
      check("rst_wait_next", 128'(d_pulses - base), 128'(1));

      // Randomized traffic, memory timing, spurious completions and resets.
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         rand_inputs();
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences one shared line-wide main-memory port between the instruction-side refill path (requester 0) and the data-cache refill/writeback path (requester 1). It sits between both caches and the backing memory model. It accepts one request at a time, issues it to memory with a valid/ready handshake, and routes the memory response back to the requester that was granted. The CPU-level stall logic uses `busy` and the per-requester handshakes to hold the pipeline.

## Interface
- `ADDR_W`, default 32: byte address width.
- `LINE_W`, default 128: line data width, one 4-word cache line.
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `i_req_valid`, `d_req_valid`  in  1  request from requester 0 / 1.
- `i_req_ready`, `d_req_ready`  out  1  request accepted this cycle.
- `i_req_write`, `d_req_write`  in  1  1 = line write, 0 = line read.
- `i_req_addr`, `d_req_addr`  in  ADDR_W  line address; low 4 bits ignored and forwarded as 0.
- `i_req_wdata`, `d_req_wdata`  in  LINE_W  write line.
- `i_resp_valid`, `d_resp_valid`  out  1  one-cycle response pulse.
- `resp_rdata`  out  LINE_W  read line, shared by both requesters and qualified by the per-requester `resp_valid`.
- `mem_req_valid`  out  1  request to memory.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_write`  out  1  write command.
- `mem_addr`  out  ADDR_W  line-aligned address.
- `mem_wdata`  out  LINE_W  write line.
- `mem_resp_valid`  in  1  memory completion (reads and writes).
- `mem_rdata`  in  LINE_W  read line.
- `busy`  out  1  state is not IDLE.
- `grant_id`  out  1  requester owning the current transaction.

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE**
  - Grant is combinational from the valid signals.
  - Exactly one `*_req_ready` is high, for the granted valid requester. Both are low when neither is valid.
  - On handshake, latch write, aligned address, wdata and `grant_id`, then go to ISSUE.
- **ISSUE**
  - `mem_req_valid`=1 with the latched fields held stable until `mem_req_ready`, then go to WAIT.
- **WAIT**
  - Hold until `mem_resp_valid`.
  - Register `mem_rdata` into `resp_rdata`, then go to RESP.
- **RESP**
  - Assert `i_resp_valid` or `d_resp_valid` for one cycle, per `grant_id`.
  - Write responses still pulse; `resp_rdata` is don't-care for writes.
  - Go to IDLE.
- **Ignored responses**
  - `mem_resp_valid` in IDLE, ISSUE or RESP is ignored; it is spurious or stale.
  - Both requesters are ready-low outside IDLE.
- **Contention**
  - Default: the data side wins when both are valid in IDLE.
  - A single requester is always granted regardless of policy.
- **Reset values**
  - All outputs 0.
  - State IDLE.
  - `grant_id` 0.
  - `resp_rdata` 0.
  - Round-robin pointer `last_grant` 0.

## Timing
- Request accepted at cycle T.
- `mem_req_valid` is high from T+1.
- With `mem_req_ready` at T+1 and `mem_resp_valid` at T+2 (minimum), `*_resp_valid` is high at T+3.
- Next grant is possible at T+4, so back-to-back throughput is 4 cycles per transaction minimum.
- ISSUE and WAIT each extend by one cycle per stall cycle; there is no timeout.
- Reset mid-transaction:
  - Next cycle IDLE, `mem_req_valid` low.
  - No response pulse is generated.
  - A late `mem_resp_valid` is ignored.
- A requester dropping valid before ready is legal; no transaction is started.

## Configuration
- `MEM_ARB_RR_EN`
  - Defined: on contention, grant the requester other than `last_grant`. `last_grant` updates on every accepted request. Since `last_grant` resets to 0, data wins the first contention.
  - Undefined: fixed priority, data over instruction. `last_grant` is absent.

## Structure
- Package `mem_arb_pkg`:
  - state enum (IDLE/ISSUE/WAIT/RESP)
  - requester IDs `REQ_I`=0, `REQ_D`=1
  - default `LINE_W`/`ADDR_W` constants
- Sub-module `mem_arb_grant`: combinational 2-way picker with inputs `valid[1:0]`, `last_grant`, `en`; outputs `gnt[1:0]` and `gnt_id`. It is instantiated once, and the policy macro is applied inside it.

## Test plan
- Single read: `d_req` of addr 0x0000_1234, memory ready immediately, response after 1 cycle with `mem_rdata`=0xA5…A5 → `mem_addr`=0x0000_1230, `d_resp_valid` at T+3 with rdata 0xA5…A5, `i_resp_valid` never high.
- Contention with the macro off: both valid continuously for 3 transactions → all three grants to D; I is granted only after `d_req_valid` drops.
- Contention with `MEM_ARB_RR_EN`: both valid continuously for 4 transactions → grant order D, I, D, I.
- Memory stalls: `mem_req_ready` low 3 cycles, then response 5 cycles later → `mem_*` fields stable throughout, single response pulse, `busy` high for the whole span.
- Write then read on I: write 0x0000_0040, then read the same address → `mem_write` 1 then 0, two `i_resp_valid` pulses, second carries the memory data.
- Reset in WAIT, then `mem_resp_valid` arrives after reset → no resp pulse, state IDLE, next request handled normally.
